// File: rtl/uart_frame_scheduler.sv
// Shares one byte-level UART TX between periodic speed telemetry and asynchronous
// events, framing each as [SYNC, TYPE, P_HI, P_LO, CHK].
module uart_frame_scheduler #(
  parameter int unsigned PERIOD    = 50000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [15:0]      speed_i,
  input  logic             evt_req,
  input  logic [7:0]       evt_code,
  output logic             evt_ack,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] overrun_cnt
);

  localparam int unsigned PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  state_t state;

  logic [PW-1:0] period_cnt;
  logic          pending;
  logic          last_evt;
  logic [15:0]   spd_reg;
  logic [7:0]    f_type;
  logic [7:0]    f_hi;
  logic [7:0]    f_lo;
  logic [2:0]    idx;

  logic          tick;
  logic          evt_grant;
  logic          spd_grant;
  logic [7:0]    cur_byte;

  // A pending sample only counts while sampling is enabled, since en=0 drops it.
  // After an event frame, a waiting speed frame wins so neither source starves.
  always_comb begin
    tick      = en && (period_cnt == LAST);
    evt_grant = (state == IDLE) && evt_req && !(last_evt && pending && en);
    spd_grant = (state == IDLE) && pending && en && !evt_grant;
    case (idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = f_type;
      3'd2:    cur_byte = f_hi;
      3'd3:    cur_byte = f_lo;
      default: cur_byte = f_type ^ f_hi ^ f_lo;
    endcase
  end

  // A tick landing on a speed grant refills pending without counting as an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt  <= '0;
      pending     <= 1'b0;
      spd_reg     <= '0;
      overrun_cnt <= '0;
    end else if (!en) begin
      period_cnt <= '0;
      pending    <= 1'b0;
    end else begin
      period_cnt <= tick ? '0 : period_cnt + 1'b1;
      if (tick) begin
        spd_reg <= speed_i;
        pending <= 1'b1;
        if (pending && !spd_grant && (overrun_cnt != '1))
          overrun_cnt <= overrun_cnt + 1'b1;
      end else if (spd_grant) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      f_type     <= '0;
      f_hi       <= '0;
      f_lo       <= '0;
      last_evt   <= 1'b0;
      evt_ack    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      evt_ack    <= 1'b0;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (evt_grant) begin
            evt_ack  <= 1'b1;
            f_type   <= 8'h02;
            f_hi     <= evt_code;
            f_lo     <= 8'h00;
            last_evt <= 1'b1;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end else if (spd_grant) begin
            f_type   <= 8'h01;
            f_hi     <= spd_reg[15:8];
            f_lo     <= spd_reg[7:0];
            last_evt <= 1'b0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: state <= SEND;
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= cur_byte;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (idx == 3'd4) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
